// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, 2 async read ports, 1 sync write port,
//   post-reset hardware clear sequencer and a combinational debug window.
// Latency: reads combinational; writes visible after the next posedge; ready rises
//   NUM_REGS posedges after rst_n deasserts.
// Backpressure: none; writes presented while not ready are silently dropped.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ra, rb            read indices       -> busa, busb read data
//   rw, busw, we      write index, data, enable
//   ready             clear sequence done, file usable
//   wr_ack            registered pulse: a write was committed on the previous edge
//   dbg_win           regs[DBG_BASE .. DBG_BASE+DBG_N-1], lowest index in the LSBs
//
// Optional build macro: REGFILE_BYPASS_EN
//   defined   -> same-cycle write-to-read forwarding on busa/busb (not on dbg_win)
//   undefined -> reads always return the pre-edge array contents

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int DBG_BASE = 4,
    parameter int DBG_N    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       ra,
    input  logic [ADDR_W-1:0]       rb,
    output logic [DATA_W-1:0]       busa,
    output logic [DATA_W-1:0]       busb,
    input  logic [ADDR_W-1:0]       rw,
    input  logic [DATA_W-1:0]       busw,
    input  logic                    we,
    output logic                    ready,
    output logic                    wr_ack,
    output logic [DBG_N*DATA_W-1:0] dbg_win
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic                ready_q, ready_d;
    logic                wr_ack_q, wr_ack_d;

    // Storage has no reset; the clear sequencer zeroes it after every reset.
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    // Array write port, shared between the clear sequencer and normal writes.
    logic                arr_we;
    logic [ADDR_W-1:0]   arr_idx;
    logic [DATA_W-1:0]   arr_dat;

    logic                run;
    logic                wr_to_zero;
    logic                commit;

    assign run        = (state_q == ST_RUN);
    assign wr_to_zero = (ZERO_REG != 0) && (rw == '0);
    // A write is committed only in RUN and never to the hardwired zero register.
    assign commit     = run && we && !wr_to_zero;

    // ------------------------------------------------------------------
    // Sequencer: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                // Stop on the all-ones index; the counter never wraps back to 0,
                // so RUN is reached exactly once per reset.
                if (clr_idx_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // ready is registered from the next state so it rises on the same edge
    // that completes the final clear write.
    always_comb begin
        ready_d  = (state_d == ST_RUN);
        wr_ack_d = commit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            wr_ack_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
            wr_ack_q  <= wr_ack_d;
        end
    end

    assign ready  = ready_q;
    assign wr_ack = wr_ack_q;

    // ------------------------------------------------------------------
    // Storage write port
    // ------------------------------------------------------------------
    // In CLEAR the sequencer owns the port and we is ignored. A clear write
    // may also occur while rst_n is held low; it only writes zero to index 0,
    // which the sequencer rewrites anyway.
    always_comb begin
        arr_we  = 1'b0;
        arr_idx = rw;
        arr_dat = busw;
        if (!run) begin
            arr_we  = 1'b1;
            arr_idx = clr_idx_q;
            arr_dat = '0;
        end else if (commit) begin
            arr_we  = 1'b1;
            arr_idx = rw;
            arr_dat = busw;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            regs_q[arr_idx] <= arr_dat;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    // Zero forcing wins over forwarding: a write to index 0 is never
    // committed, so commit already excludes it, but the ordering makes the
    // intent explicit.
    always_comb begin
        busa = regs_q[ra];
        busb = regs_q[rb];

        if (!run || ((ZERO_REG != 0) && (ra == '0))) begin
            busa = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (commit && (ra == rw)) begin
            busa = busw;
        end
`endif

        if (!run || ((ZERO_REG != 0) && (rb == '0))) begin
            busb = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (commit && (rb == rw)) begin
            busb = busw;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Debug window: never forwarded, same zero/CLEAR forcing as the read ports
    // ------------------------------------------------------------------
    for (genvar g = 0; g < DBG_N; g++) begin : g_dbg
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(DBG_BASE + g);
        localparam bit                IS_ZERO = (ZERO_REG != 0) && (DBG_BASE + g == 0);

        assign dbg_win[g*DATA_W +: DATA_W] = (run && !IS_ZERO) ? regs_q[IDX] : '0;
    end

endmodule
